bcd_7seg_scan: RTL
==================

# bcd_7seg_scan

Time-multiplexed two-digit seven-segment display driver for the packed 8-bit BCD values produced by the team's BCD counters, including the 00–59 up/down counter. It latches a packed BCD value on a load strobe and scans the tens and units digits onto one shared segment bus with one-hot digit enables. It also provides optional leading-zero blanking, an `E` glyph and error flag for non-BCD nibbles, and selectable common-anode polarity. It sits between the counter output and the board display pins.

## Interface
- `SCAN_DIV`, default 4: clock cycles each digit stays enabled before the scan advances. Legal range is 1..256; the divider width is ceil(log2(SCAN_DIV)), minimum 1.
- `COMMON_ANODE`, default 0: 0 means `seg` and `an` are active-high; 1 means both are inverted at the output register.
- `clock`  in  1  single clock; all state updates on the falling edge.
- `reset`  in  1  synchronous, active-low reset, sampled on the falling edge of `clock`.
- `load`  in  1  when 1 at an active edge, `bcd_in` is captured.
- `bcd_in`  in  8  packed BCD; [7:4] is tens, [3:0] is units.
- `blank_lz`  in  1  when 1, a tens digit of 0 is blanked.
- `seg`  out  7  segments {a,b,c,d,e,f,g}; `seg[6]` is a. Registered.
- `an`  out  2  digit enables; `an[0]` is units, `an[1]` is tens. Registered.
- `err`  out  1  1 while the latched value contains a nibble greater than 9. Registered.

## Operation
- State: `val[7:0]` latched value, `div` scan divider, `digit` (0 = units, 1 = tens).
- Reset (reset==0 at an active edge) sets: `val`=8'h00, `div`=0, `digit`=0, `err`=0, seg/an all segments and digits off. With COMMON_ANODE=1 the off state is seg=7'h7F, an=2'b11. Reset overrides `load`.
- Load: at an edge with `load`=1:
  - `val` <= `bcd_in`.
  - `err` <= (`bcd_in[7:4]`>9) | (`bcd_in[3:0]`>9).
  - Back-to-back loads are legal; the last one wins.
  - Loading does not disturb `div` or `digit`.
- Scan, at every non-reset edge:
  - If `div`==SCAN_DIV-1, then `div` <= 0 and `digit` <= ~`digit`.
  - Otherwise `div` <= `div`+1.
- Output register, at every non-reset edge, computed from the pre-edge `val` and `digit`:
  - Selected nibble n = `digit` ? `val[7:4]` : `val[3:0]`.
  - an = `digit` ? 2'b10 : 2'b01.
  - seg = glyph(n).
  - Blanking: if `digit`==1, `blank_lz`==1 and `val[7:4]`==0, then an=2'b00 and seg=7'h00. The units digit is never blanked, so 00 shows "0".
- Glyphs, abcdefg:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - Any value 10..15 = 1001111 (E).
- Polarity: with COMMON_ANODE=1, the final seg and an are bitwise inverted, including the blank and reset states.

## Timing
- Load to display: a value loaded at edge N appears on seg/an at edge N+1, provided the current `digit` selects that nibble. Otherwise it appears at the edge after the next digit switch.
- `err` updates at the load edge itself (edge N).
- Digit period: each digit drives the outputs for exactly SCAN_DIV consecutive edges. The full refresh frame is 2·SCAN_DIV edges.
- First outputs after reset release:
  - First non-reset edge: an=01 and seg shows the units of `val`.
  - With SCAN_DIV=1, the outputs alternate units and tens on every edge.
- A digit switch and a load on the same edge are independent; no cycle is skipped or repeated.
- Reset asserted mid-frame: outputs are off at that edge, and the scan restarts on the units digit with `div`=0.

## Test plan
- Reset then idle, SCAN_DIV=4, no load: an follows 01,01,01,01,10,10,10,10 from the first non-reset edge; seg=1111110 throughout; err=0.
- Load 8'h59 with blank_lz=0: units slots show seg=1111011, an=01; tens slots show seg=1011011, an=10; err=0.
- Load 8'h07 with blank_lz=1: tens slots give an=00, seg=0000000; units slots give seg=1110000, an=01. Then load 8'h00: the units digit shows 1111110 and the tens digit stays blank.
- Load 8'h5A: err=1 at the load edge; units slots show E (1001111). Then load 8'h12: err returns to 0 and the digits show 1 and 2.
- COMMON_ANODE=1: after reset, seg=7'h7F and an=2'b11. Then load 8'h30: units slots give an=2'b10 and seg=0000001.
- Drive reset=0 for one edge while on the tens digit at div=2 after loading 8'h45: that edge gives outputs off (COMMON_ANODE=0), `val`=8'h00 and err=0. The next edge shows units 0 with an=01, and the scan counts a full SCAN_DIV before switching.

Source files
------------

// File: rtl/bcd_7seg_scan_if.sv
// Counter-to-display link for the two-digit seven-segment scanner.
// The master side supplies the BCD value and strobes, and the slave side drives the display pins.
interface bcd_7seg_scan_if;
  logic       load;
  logic [7:0] bcd_in;
  logic       blank_lz;
  logic [6:0] seg;
  logic [1:0] an;
  logic       err;

  modport master (output load, bcd_in, blank_lz, input  seg, an, err);
  modport slave  (input  load, bcd_in, blank_lz, output seg, an, err);
endinterface

// File: rtl/bcd_7seg_scan.sv
// Two-digit multiplexed seven-segment driver for packed BCD. It latches a value on load
// and scans the units and tens digits onto a shared segment bus, with optional leading-zero blanking.
module bcd_7seg_scan #(
  parameter int SCAN_DIV     = 4,
  parameter bit COMMON_ANODE = 1'b0
) (
  input logic             clock,
  input logic             reset,
  bcd_7seg_scan_if.slave  bus
);

  localparam int                DIV_W    = (SCAN_DIV <= 1) ? 1 : $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [6:0]        SEG_POL  = {7{COMMON_ANODE}};
  localparam logic [1:0]        AN_POL   = {2{COMMON_ANODE}};

  logic [7:0]       val;
  logic [DIV_W-1:0] div;
  logic             digit;
  logic             err_q;
  logic [6:0]       seg_q;
  logic [1:0]       an_q;

  logic [3:0]       nib;
  logic [6:0]       seg_raw;
  logic [1:0]       an_raw;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'd0:    glyph = 7'b1111110;
      4'd1:    glyph = 7'b0110000;
      4'd2:    glyph = 7'b1101101;
      4'd3:    glyph = 7'b1111001;
      4'd4:    glyph = 7'b0110011;
      4'd5:    glyph = 7'b1011011;
      4'd6:    glyph = 7'b1011111;
      4'd7:    glyph = 7'b1110000;
      4'd8:    glyph = 7'b1111111;
      4'd9:    glyph = 7'b1111011;
      default: glyph = 7'b1001111; // "E" for any non-BCD nibble
    endcase
  endfunction

  // NOTE: every output of this block is assigned before any condition, so no latch is inferred.
  always_comb begin
    nib     = digit ? val[7:4] : val[3:0];
    seg_raw = glyph(nib);
    an_raw  = digit ? 2'b10 : 2'b01;
    if (digit && bus.blank_lz && (val[7:4] == 4'd0)) begin
      seg_raw = 7'h00;
      an_raw  = 2'b00;
    end
  end

  // All state moves on the falling edge. The output register samples the pre-edge val and digit.
  // NOTE: sequential state uses non-blocking assignments, so every register sees pre-edge values.
  always_ff @(negedge clock) begin
    if (!reset) begin
      val   <= 8'h00;
      div   <= '0;
      digit <= 1'b0;
      err_q <= 1'b0;
      seg_q <= SEG_POL;
      an_q  <= AN_POL;
    end else begin
      if (bus.load) begin
        val   <= bus.bcd_in;
        err_q <= (bus.bcd_in[7:4] > 4'd9) | (bus.bcd_in[3:0] > 4'd9);
      end
      if (div == DIV_LAST) begin
        div   <= '0;
        digit <= ~digit;
      end else begin
        div   <= div + 1'b1;
      end
      seg_q <= seg_raw ^ SEG_POL;
      an_q  <= an_raw ^ AN_POL;
    end
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;
  assign bus.err = err_q;

endmodule
